inconsistency_monitor: RTL

Parametrised, clocked successor to the three-switch inconsistency circuit on the EGO1 board. It watches N_IN switch inputs, synchronises and debounces them, and flags any cycle where the inputs are not all equal. A live/latched alarm state machine and a saturating mismatch-event counter drive the LED bank directly. It is a top-level board block: switches in, LEDs out.

---
 rtl/inconsistency_monitor_pkg.sv | 18 +
 rtl/inconsistency_monitor_sw_debounce.sv | 44 ++++
 rtl/inconsistency_monitor.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/inconsistency_monitor_pkg.sv
// Shared types and bit positions for the switch inconsistency monitor.
package inconsistency_monitor_pkg;

  typedef enum logic [1:0] {
    OK      = 2'd0,
    FAULT   = 2'd1,
    LATCHED = 2'd2
  } mon_state_e;

  localparam int LED_MIS     = 0;
  localparam int LED_ALARM   = 1;
  localparam int LED_LATCH   = 2;
  localparam int LED_CNT_LSB = 8;

  localparam int SW_CLR  = 6;
  localparam int SW_MODE = 7;

endpackage

// File: rtl/inconsistency_monitor_sw_debounce.sv
// One switch channel: two-flop synchroniser followed by a stable-count debouncer.
module sw_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk_pin,
  input  logic rst_n_pin,
  input  logic raw,
  output logic db
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_pin or negedge rst_n_pin) begin
    if (!rst_n_pin) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      // the debounced bit only moves after DEB_CYCLES consecutive differing samples
      if (sync2_q != db_q) begin
        if (cnt_q == LAST) begin
          db_q  <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign db = db_q;

endmodule

// File: rtl/inconsistency_monitor.sv
// Board-level monitor: debounced switch vote, live/latched alarm FSM and
// saturating mismatch-event counter driving the LED bank.
//
// state   | meaning
// OK      | debounced inputs agree, no alarm pending
// FAULT   | debounced inputs currently disagree
// LATCHED | disagreement has cleared in latched mode; waits for a clear pulse
module inconsistency_monitor
  import inconsistency_monitor_pkg::*;
#(
  parameter int N_IN       = 3,
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 8
) (
  input  logic        clk_pin,
  input  logic        rst_n_pin,
  input  logic [7:0]  sw_pin,
  output logic [15:0] led_pin
);

  localparam int NCH = N_IN + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NCH-1:0] raw_sel;
  logic [NCH-1:0] db_all;
  logic [N_IN-1:0] db_in;
  logic           db_clr;
  logic           db_mode;
  logic           unused_sw;

  assign raw_sel   = {sw_pin[SW_MODE], sw_pin[SW_CLR], sw_pin[N_IN-1:0]};
  assign unused_sw = ^sw_pin;

  for (genvar i = 0; i < NCH; i++) begin : g_deb
    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk_pin   (clk_pin),
      .rst_n_pin (rst_n_pin),
      .raw       (raw_sel[i]),
      .db        (db_all[i])
    );
  end

  assign db_in   = db_all[N_IN-1:0];
  assign db_clr  = db_all[N_IN];
  assign db_mode = db_all[N_IN+1];

  mon_state_e       state_q;
  logic             alarm_q;
  logic             latch_q;
  logic             mismatch_d;
  logic             mismatch_q;
  logic             clr_db_q;
  logic             mis_rise;
  logic             clr_pulse;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;
  logic [7:0]       cnt_ext;

  always_comb begin
    mismatch_d = (|db_in) & ~(&db_in);
    mis_rise   = mismatch_d & ~mismatch_q;
    clr_pulse  = db_clr & ~clr_db_q;

    // a new mismatch beats a simultaneous clear: the event is still counted
    count_d = count_q;
    if (mis_rise) begin
      if (clr_pulse)               count_d = CNT_W'(1);
      else if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
    end else if (clr_pulse) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_pin or negedge rst_n_pin) begin
    if (!rst_n_pin) begin
      mismatch_q <= 1'b0;
      clr_db_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      mismatch_q <= mismatch_d;
      clr_db_q   <= db_clr;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_pin or negedge rst_n_pin) begin
    if (!rst_n_pin) begin
      state_q <= OK;
      alarm_q <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      case (state_q)
        OK: begin
          if (mismatch_d) begin
            state_q <= FAULT;
            alarm_q <= 1'b1;
          end
        end
        FAULT: begin
          // mode is sampled only at the moment the disagreement clears
          if (!mismatch_d) begin
            if (db_mode) begin
              state_q <= LATCHED;
              latch_q <= 1'b1;
            end else begin
              state_q <= OK;
              alarm_q <= 1'b0;
            end
          end
        end
        LATCHED: begin
          if (mismatch_d) begin
            state_q <= FAULT;
            latch_q <= 1'b0;
          end else if (clr_pulse) begin
            state_q <= OK;
            alarm_q <= 1'b0;
            latch_q <= 1'b0;
          end
        end
        default: begin
          state_q <= OK;
          alarm_q <= 1'b0;
          latch_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cnt_ext              = '0;
    cnt_ext[CNT_W-1:0]   = count_q;
    led_pin              = '0;
    led_pin[LED_MIS]     = mismatch_q;
    led_pin[LED_ALARM]   = alarm_q;
    led_pin[LED_LATCH]   = latch_q;
    led_pin[LED_CNT_LSB +: 8] = cnt_ext;
  end

endmodule
